layerio_rd_sequencer: RTL and testbench
=======================================

// Module: layerio_rd_sequencer
// PURPOSE
// Consumer-side read sequencer for the layer-IO memory front end. Once per layer it issues
// exactly N layerio read requests, gated by rdready and by a credit count equal to its return
// buffer depth. Returned words go into a local FIFO and are presented to the downstream MXU
// input stage on a valid/ready stream with a last marker. Single clock domain (topclk side).
// PARAMETERS
// WIDTH     64  width of one returned layerio word (SZJ*A_WIDTH in the top level)
// CNT_W     32  width of layer read-count and internal counters
// CREDITS    8  return-buffer depth = max reads in flight; power of 2, >=2
// PORTS
// clk         in   1      clock
// resetn      in   1      reset
// start       in   1      pulse: begin a layer; sampled only in IDLE
// total_reads in   CNT_W  reads for this layer; sampled with start
// abort       in   1      synchronous flush; priority over all other inputs
// rdready     in   1      layerio front end can accept a read request
// rdreq       out  1      read request to layerio (one word per asserted cycle)
// q_valid     in   1      returned word valid (fixed-latency return from layerio)
// q_value     in   WIDTH  returned word
// out_valid   out  1      return-buffer head valid
// out_data    out  WIDTH  return-buffer head word
// out_last    out  1      head is word total_reads-1 of the layer
// out_ready   in   1      downstream accepts head when out_valid & out_ready
// busy        out  1      state != IDLE
// done        out  1      1-cycle pulse after the last word is popped
// err         out  1      sticky: overflow or unexpected q_valid; cleared only by reset
// BEHAVIOUR
// Reset (resetn asynchronous, active-low; clock clk):
//  - state=IDLE; counters 0; credits=CREDITS; buffer empty.
//  - Outputs rdreq, out_valid, out_last, busy, done, err all 0.
// Counters:
//  - issued and popped count 0..total_reads; inflight = issued - received.
//  - All counters CNT_W bits, no wrap; total_reads <= 2^CNT_W-1.
// FSM IDLE -> ISSUE -> DRAIN -> IDLE:
//  - IDLE: start & total_reads==0 gives done next cycle and stays IDLE.
//  - IDLE: start & total_reads>0 latches total and goes to ISSUE.
//  - ISSUE -> DRAIN when issued reaches total (same cycle as the last rdreq).
//  - DRAIN -> IDLE on the pop of the last word; done asserts in the following cycle.
//  - start is ignored outside IDLE.
// Issue:
//  - rdreq = (state==ISSUE) & rdready & (credits!=0) & (issued<total).
//  - rdreq is combinational from registered state only; the rdready path is one AND gate.
// Credits:
//  - -1 on rdreq, +1 on pop; both in one cycle leaves credits unchanged.
//  - Never exceeds CREDITS and never goes below 0 (assertion).
// Buffer:
//  - FIFO of depth CREDITS, first-word-fall-through.
//  - A push on q_valid becomes visible on out_valid the next cycle.
//  - Simultaneous push and pop on a full buffer is legal.
//  - A push on a full buffer with no pop is dropped and sets err.
// out_last:
//  - out_last = out_valid & (popped == total-1).
//  - Each word carries its own last bit, so back-to-back layers stay correct.
// Unexpected q_valid:
//  - q_valid in IDLE with inflight==0 and no discard pending: data dropped, err set.
// Abort:
//  - Next cycle: state=IDLE, buffer flushed, credits=CREDITS, issued/popped=0.
//  - The current inflight value is loaded into a discard counter.
//  - The next `discard` q_valid returns are dropped silently; no err, not pushed.
//  - start is accepted during discard. New-layer pushes begin only after discard reaches 0.
//  - abort and start in the same cycle: abort wins.
// No combinational path from q_valid/q_value to any output.
// TESTING
// 1. total_reads=20, rdready=1, out_ready=1, latency 5 -> 20 rdreq cycles, 20 ordered words,
//    out_last only on word 19, done 1 cycle after pop 19, err=0.
// 2. total_reads=32, out_ready=0 -> rdreq stops after exactly 8 issues; release out_ready
//    -> all 32 delivered, credits never <0 or >8.
// 3. total_reads=0 -> no rdreq, done pulses one cycle after start, busy stays 0.
// 4. rdready toggled random 50%, out_ready random 30%, total_reads=100 -> data matches
//    memory model in order, issued==popped==100 at done.
// 5. abort with 6 reads in flight, start 40 the next cycle -> the 6 stale returns are dropped,
//    the next 40 words are correct, err=0.
// 6. Inject q_valid in IDLE with nothing pending -> err=1 and stays 1 until resetn; resetn
//    mid-layer returns all outputs to reset values.

Source files
------------

// File: rtl/layerio_rd_sequencer.sv
// Layer read sequencer: issues N credit-gated layerio reads per layer and streams the
// returned words out of a first-word-fall-through buffer with a per-word last marker.
module layerio_rd_sequencer #(
  parameter int WIDTH   = 64,
  parameter int CNT_W   = 32,
  parameter int CREDITS = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [CNT_W-1:0] total_reads,
  input  logic             abort,
  input  logic             rdready,
  output logic             rdreq,
  input  logic             q_valid,
  input  logic [WIDTH-1:0] q_value,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int AW = $clog2(CREDITS);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] total_reg, total_next;
  logic [CNT_W-1:0] issued_reg, issued_next;
  logic [CNT_W-1:0] received_reg, received_next;
  logic [CNT_W-1:0] popped_reg, popped_next;
  logic [CNT_W-1:0] discard_reg, discard_next;
  logic [CW-1:0]    credits_reg, credits_next;
  logic [CW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic [WIDTH-1:0] data_mem [CREDITS];
  logic             last_mem [CREDITS];

  logic             empty, full, pop, push, push_last;
  logic             take_disc, unexpected, recv;
  logic [CNT_W-1:0] inflight, inflight_after;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign rdreq     = (state_reg == ISSUE) & rdready & (credits_reg != '0) & (issued_reg < total_reg);
  assign out_valid = ~empty;
  assign out_data  = data_mem[rd_ptr_reg[AW-1:0]];
  assign out_last  = out_valid & last_mem[rd_ptr_reg[AW-1:0]];
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

  assign pop        = out_valid & out_ready;
  assign inflight   = issued_reg - received_reg;
  // Stale returns after an abort are swallowed before anything else looks at q_valid.
  assign take_disc  = q_valid & (discard_reg != '0);
  assign unexpected = q_valid & ~take_disc & (inflight == '0);
  assign recv       = q_valid & ~take_disc & ~unexpected;
  assign push       = recv & (~full | pop);
  assign push_last  = (received_reg == total_reg - CNT_W'(1));
  // Reads still outstanding once this cycle's request and return are accounted for.
  assign inflight_after = issued_reg + CNT_W'(rdreq) - received_reg - CNT_W'(recv);

  always_comb begin
    state_next    = state_reg;
    total_next    = total_reg;
    issued_next   = issued_reg + CNT_W'(rdreq);
    received_next = received_reg + CNT_W'(recv);
    popped_next   = popped_reg + CNT_W'(pop);
    discard_next  = discard_reg - CNT_W'(take_disc);
    credits_next  = credits_reg - CW'(rdreq) + CW'(pop);
    wr_ptr_next   = wr_ptr_reg + CW'(push);
    rd_ptr_next   = rd_ptr_reg + CW'(pop);
    done_next     = 1'b0;
    err_next      = err_reg | unexpected | (recv & full & ~pop);

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (total_reads == '0) begin
            done_next = 1'b1;
          end else begin
            total_next    = total_reads;
            issued_next   = '0;
            received_next = '0;
            popped_next   = '0;
            state_next    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (rdreq && (issued_reg + CNT_W'(1) == total_reg)) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort) begin
      state_next    = IDLE;
      issued_next   = '0;
      received_next = '0;
      popped_next   = '0;
      credits_next  = CW'(CREDITS);
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      discard_next  = discard_reg - CNT_W'(take_disc) + inflight_after;
      done_next     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      total_reg    <= '0;
      issued_reg   <= '0;
      received_reg <= '0;
      popped_reg   <= '0;
      discard_reg  <= '0;
      credits_reg  <= CW'(CREDITS);
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      total_reg    <= total_next;
      issued_reg   <= issued_next;
      received_reg <= received_next;
      popped_reg   <= popped_next;
      discard_reg  <= discard_next;
      credits_reg  <= credits_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg[AW-1:0]] <= q_value;
      last_mem[wr_ptr_reg[AW-1:0]] <= push_last;
    end
  end

  assert property (@(posedge clk) disable iff (!resetn) credits_reg <= CW'(CREDITS));
  assert property (@(posedge clk) disable iff (!resetn)
                   !(pop && !rdreq && (credits_reg == CW'(CREDITS))));
endmodule

// File: tb/tb_layerio_rd_sequencer.sv
// Directed bench for layerio_rd_sequencer with a fixed-latency (5) layerio return model.
module tb_layerio_rd_sequencer;
  logic        clk = 1'b0;
  logic        resetn, start, abort, rdready, out_ready, rdreq;
  logic [31:0] total_reads;
  logic        q_valid, out_valid, out_last, busy, done, err;
  logic [63:0] q_value, out_data;
  logic        inj_v;
  logic [63:0] inj_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  layerio_rd_sequencer #(.WIDTH(64), .CNT_W(32), .CREDITS(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .total_reads(total_reads), .abort(abort),
    .rdready(rdready), .rdreq(rdreq), .q_valid(q_valid), .q_value(q_value),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [63:0] mk(input int i);
    logic [31:0] u;
    u = i;
    return {~u, u};
  endfunction

  // Layerio model: request number mcnt returns mk(mcnt) five clocks later.
  logic [4:0]       pv;
  logic [4:0][63:0] pd;
  int               mcnt = 0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pv <= '0;
    end else begin
      pv <= {pv[3:0], rdreq};
      pd <= {pd[3:0], mk(mcnt)};
      if (rdreq) mcnt <= mcnt + 1;
    end
  end
  assign q_valid = pv[4] | inj_v;
  assign q_value = inj_v ? inj_d : pd[4];

  logic [63:0] pop_data [4096];
  logic        pop_last [4096];
  int          n_pop = 0, n_done = 0, cyc = 0, last_pop_cyc = 0, last_done_cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) begin
      pop_data[n_pop] <= out_data;
      pop_last[n_pop] <= out_last;
      n_pop           <= n_pop + 1;
      last_pop_cyc    <= cyc;
    end
    if (done) begin
      n_done        <= n_done + 1;
      last_done_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_layer(input int n, input int rdy_pct, input int ordy_pct,
                           input int budget, output bit timed_out);
    int d0 = n_done;
    int c  = 0;
    timed_out   = 1'b0;
    start       = 1'b1;
    total_reads = n;
    rdready     = ($urandom_range(0, 99) < rdy_pct);
    out_ready   = ($urandom_range(0, 99) < ordy_pct);
    tick();
    start = 1'b0;
    while (n_done == d0) begin
      if (c >= budget) begin
        timed_out = 1'b1;
        break;
      end
      rdready   = ($urandom_range(0, 99) < rdy_pct);
      out_ready = ($urandom_range(0, 99) < ordy_pct);
      tick();
      c++;
    end
    rdready   = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; abort = 1'b0; rdready = 1'b0; out_ready = 1'b0;
    total_reads = '0; inj_v = 1'b0; inj_d = '0;
    repeat (3) tick();
    checks++;
    if ({rdreq, out_valid, out_last, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", {rdreq, out_valid, out_last, busy, done, err});
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%0b out_valid=%0b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic();
    int r0 = mcnt;
    int p0 = n_pop;
    bit to;
    run_layer(20, 100, 100, 500, to);
    checks++;
    if (to) begin errors++; $display("FAIL t1_timeout: done not seen, expected done"); end
    checks++;
    if (mcnt - r0 !== 20) begin errors++; $display("FAIL t1_reqs: got %0d expected 20", mcnt - r0); end
    checks++;
    if (n_pop - p0 !== 20) begin errors++; $display("FAIL t1_pops: got %0d expected 20", n_pop - p0); end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (pop_data[p0+k] !== mk(r0 + k) || pop_last[p0+k] !== (k == 19)) begin
        errors++;
        $display("FAIL t1_word%0d: got %h last=%0b expected %h last=%0b",
                 k, pop_data[p0+k], pop_last[p0+k], mk(r0 + k), (k == 19));
      end
    end
    checks++;
    if (last_done_cyc !== last_pop_cyc + 1) begin
      errors++;
      $display("FAIL t1_done_timing: done cycle %0d expected %0d", last_done_cyc, last_pop_cyc + 1);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL t1_err: got %0b expected 0", err); end
  endtask

  task automatic test_backpressure();
    int r0 = mcnt;
    int p0 = n_pop;
    int d0 = n_done;
    int mx = 0;
    int c  = 0;
    start = 1'b1; total_reads = 32; rdready = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    repeat (30) tick();
    checks++;
    if (mcnt - r0 !== 8) begin errors++; $display("FAIL t2_credit_stall: got %0d reqs expected 8", mcnt - r0); end
    checks++;
    if (out_valid !== 1'b1 || n_pop !== p0) begin
      errors++;
      $display("FAIL t2_held: out_valid=%0b pops=%0d expected 1 0", out_valid, n_pop - p0);
    end
    out_ready = 1'b1;
    while (n_done == d0 && c < 500) begin
      tick();
      c++;
      if ((mcnt - r0) - (n_pop - p0) > mx) mx = (mcnt - r0) - (n_pop - p0);
    end
    checks++;
    if (n_done == d0) begin errors++; $display("FAIL t2_timeout: done not seen, expected done"); end
    checks++;
    if (mx > 8) begin errors++; $display("FAIL t2_outstanding: got %0d expected <=8", mx); end
    checks++;
    if (n_pop - p0 !== 32 || mcnt - r0 !== 32) begin
      errors++;
      $display("FAIL t2_counts: pops=%0d reqs=%0d expected 32 32", n_pop - p0, mcnt - r0);
    end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (pop_data[p0+k] !== mk(r0 + k) || pop_last[p0+k] !== (k == 31)) begin
        errors++;
        $display("FAIL t2_word%0d: got %h last=%0b expected %h last=%0b",
                 k, pop_data[p0+k], pop_last[p0+k], mk(r0 + k), (k == 31));
      end
    end
  endtask

  task automatic test_zero_reads();
    int r0 = mcnt;
    start = 1'b1; total_reads = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL t3_before: busy=%0b done=%0b expected 0 0", busy, done);
    end
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t3_done_pulse: done=%0b busy=%0b expected 1 0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mcnt !== r0) begin
      errors++;
      $display("FAIL t3_after: done=%0b busy=%0b reqs=%0d expected 0 0 0", done, busy, mcnt - r0);
    end
  endtask

  task automatic test_random_flow();
    int r0 = mcnt;
    int p0 = n_pop;
    bit to;
    run_layer(100, 50, 30, 4000, to);
    checks++;
    if (to) begin errors++; $display("FAIL t4_timeout: done not seen, expected done"); end
    checks++;
    if (mcnt - r0 !== 100 || n_pop - p0 !== 100) begin
      errors++;
      $display("FAIL t4_counts: reqs=%0d pops=%0d expected 100 100", mcnt - r0, n_pop - p0);
    end
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (pop_data[p0+k] !== mk(r0 + k) || pop_last[p0+k] !== (k == 99)) begin
        errors++;
        $display("FAIL t4_word%0d: got %h last=%0b expected %h last=%0b",
                 k, pop_data[p0+k], pop_last[p0+k], mk(r0 + k), (k == 99));
      end
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL t4_err: got %0b expected 0", err); end
  endtask

  task automatic test_abort();
    int a0 = mcnt;
    int c  = 0;
    int b0, p0;
    bit to;
    start = 1'b1; total_reads = 40; rdready = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    while (mcnt - a0 < 6 && c < 50) begin
      tick();
      c++;
    end
    rdready = 1'b0;
    abort   = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (mcnt - a0 !== 6) begin errors++; $display("FAIL t5_issued: got %0d expected 6", mcnt - a0); end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_flush: busy=%0b out_valid=%0b expected 0 0", busy, out_valid);
    end
    b0 = mcnt;
    p0 = n_pop;
    run_layer(40, 100, 100, 1000, to);
    checks++;
    if (to) begin errors++; $display("FAIL t5_timeout: done not seen, expected done"); end
    checks++;
    if (mcnt - b0 !== 40 || n_pop - p0 !== 40) begin
      errors++;
      $display("FAIL t5_counts: reqs=%0d pops=%0d expected 40 40", mcnt - b0, n_pop - p0);
    end
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (pop_data[p0+k] !== mk(b0 + k) || pop_last[p0+k] !== (k == 39)) begin
        errors++;
        $display("FAIL t5_word%0d: got %h last=%0b expected %h last=%0b",
                 k, pop_data[p0+k], pop_last[p0+k], mk(b0 + k), (k == 39));
      end
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL t5_err: got %0b expected 0", err); end
  endtask

  task automatic test_err_and_reset();
    repeat (10) tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL t6_err_clear: got %0b expected 0", err); end
    inj_v = 1'b1; inj_d = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    inj_v = 1'b0;
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t6_err_set: err=%0b out_valid=%0b expected 1 0", err, out_valid);
    end
    start = 1'b1; total_reads = 20; rdready = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    repeat (15) tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL t6_mid_layer: err=%0b busy=%0b out_valid=%0b expected 1 1 1", err, busy, out_valid);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({rdreq, out_valid, out_last, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL t6_async_reset: got %b expected 000000", {rdreq, out_valid, out_last, busy, done, err});
    end
    tick();
    resetn = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t6_post_reset: err=%0b busy=%0b out_valid=%0b expected 0 0 0", err, busy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_reads();
    test_random_flow();
    test_abort();
    test_err_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
